// File: rtl/icache_refill_pkg.sv
// rtl/icache_refill_pkg.sv - shared types and address-geometry helpers for the instruction cache
package icache_refill_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_MEM_REQ = 3'd2,
        S_REFILL  = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    // Byte-offset bits inside one line.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words * 4);
    endfunction

    // Index bits selecting the line.
    function automatic int idx_bits(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Remaining upper address bits stored as the tag.
    function automatic int tag_bits(input int line_words, input int num_lines);
        return 32 - idx_bits(num_lines) - off_bits(line_words);
    endfunction

    // Word-select width; kept at one bit for single-word lines so vectors stay legal.
    function automatic int word_bits(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    // Clears the in-line byte offset, giving the address of the first word of the line.
    function automatic logic [31:0] line_base(input logic [31:0] addr, input int off_b);
        return addr & ~((32'd1 << off_b) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - fetch-side and memory-side handshake bundle for the instruction cache
interface icache_refill_if;

    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic [31:0] cpu_addr;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    // Cache view: serves fetch requests and issues refills.
    modport slave (
        input  cpu_req_valid, cpu_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_req_valid, mem_req_addr
    );

    // Environment view: fetch stage plus instruction memory.
    modport master (
        output cpu_req_valid, cpu_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/icache_refill_data_ram.sv
// rtl/icache_refill_data_ram.sv - line data storage, one refill write port and one async read port
module icache_refill_data_ram #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_B      = 4,
    parameter int WORD_B     = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_B-1:0]  w_idx,
    input  logic [WORD_B-1:0] w_word,
    input  logic [31:0]       wdata,
    input  logic [IDX_B-1:0]  r_idx,
    input  logic [WORD_B-1:0] r_word,
    output logic [31:0]       rdata
);

    logic [31:0] mem [NUM_LINES][LINE_WORDS];

    // Refill beats land here one word at a time; contents need no reset since valid bits gate use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_idx][w_word] <= wdata;
        end
    end

    assign rdata = mem[r_idx][r_word];

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - direct-mapped instruction cache with line refill FSM, flush and hit/miss counters
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    icache_refill_if.slave   bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int OFF_B  = off_bits(LINE_WORDS);
    localparam int IDX_B  = idx_bits(NUM_LINES);
    localparam int TAG_B  = tag_bits(LINE_WORDS, NUM_LINES);
    localparam int WORD_B = word_bits(LINE_WORDS);
    localparam logic [WORD_B-1:0] LAST_BEAT = WORD_B'(LINE_WORDS - 1);

    state_e              state_q, state_d;
    logic [31:2]         addr_q, addr_d;
    logic [WORD_B-1:0]   beat_cnt_q, beat_cnt_d;
    logic                flush_pend_q, flush_pend_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [TAG_B-1:0]    tag_q [NUM_LINES];
    logic                resp_valid_q, resp_valid_d;
    logic [31:0]         resp_data_q, resp_data_d;
    logic [CNT_W-1:0]    hit_q, hit_d, miss_q, miss_d;

    logic                tag_we;
    logic                ram_we;
    logic [TAG_B-1:0]    req_tag;
    logic [IDX_B-1:0]    req_idx;
    logic [WORD_B-1:0]   req_word;
    logic [31:0]         ram_rdata;
    logic                lookup_hit;
    logic                last_beat;

    assign req_tag = addr_q[31 -: TAG_B];
    assign req_idx = addr_q[OFF_B +: IDX_B];

    generate
        if (LINE_WORDS > 1) begin : g_word_sel
            assign req_word = addr_q[OFF_B-1:2];
        end else begin : g_word_zero
            assign req_word = '0;
        end
    endgenerate

    assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign last_beat  = (beat_cnt_q == LAST_BEAT);

    icache_refill_data_ram #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_B      (IDX_B),
        .WORD_B     (WORD_B)
    ) u_data_ram (
        .clk    (clk),
        .we     (ram_we),
        .w_idx  (req_idx),
        .w_word (beat_cnt_q),
        .wdata  (bus.mem_resp_data),
        .r_idx  (req_idx),
        .r_word (req_word),
        .rdata  (ram_rdata)
    );

    assign bus.cpu_req_ready  = (state_q == S_IDLE) && !reset;
    assign bus.cpu_resp_valid = resp_valid_q;
    assign bus.cpu_resp_data  = resp_data_q;
    assign bus.mem_req_valid  = (state_q == S_MEM_REQ);
    assign bus.mem_req_addr   = (state_q == S_MEM_REQ) ? line_base({addr_q, 2'b00}, OFF_B) : 32'd0;
    assign hit_count          = hit_q;
    assign miss_count         = miss_q;

    // Next-state, response and bookkeeping decisions for the request in flight.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beat_cnt_d   = beat_cnt_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        tag_we       = 1'b0;
        ram_we       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end
                if (bus.cpu_req_valid) begin
                    addr_d  = bus.cpu_addr[31:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // The hit decision reads valid_q, so a same-cycle flush only affects later lookups.
                if (bus.flush) begin
                    valid_d = '0;
                end
                if (lookup_hit) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = ram_rdata;
                    hit_d        = (hit_q == '1) ? hit_q : hit_q + 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    miss_d  = (miss_q == '1) ? miss_q : miss_q + 1'b1;
                    state_d = S_MEM_REQ;
                end
            end
            S_MEM_REQ: begin
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.mem_req_ready) begin
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
                if (bus.mem_resp_valid) begin
                    ram_we = 1'b1;
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        tag_we     = 1'b1;
                        valid_d[req_idx] = !(flush_pend_q || bus.flush);
                        resp_valid_d = 1'b1;
                        // The final beat is still on the bus, not yet in the RAM.
                        resp_data_d  = (req_word == LAST_BEAT) ? bus.mem_resp_data : ram_rdata;
                        state_d      = S_RESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                if (flush_pend_q || bus.flush) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state, valid bits and counters; reset drops any partial refill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            beat_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_cnt_q   <= beat_cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Tag storage is only meaningful under a set valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[req_idx] <= req_tag;
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - scoreboard bench for icache_refill with a line-level cache model
module tb_icache_refill;

    localparam int LW = 4;
    localparam int NL = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_drv, rst_resp, reset;
    logic flush_drv, flush_resp;
    logic stray_v, r_valid;
    logic [31:0] r_data;
    logic [CW-1:0] hit_count, miss_count;

    assign reset = rst_drv | rst_resp;

    icache_refill_if bus();

    assign bus.flush          = flush_drv | flush_resp;
    assign bus.mem_resp_valid = r_valid | stray_v;
    assign bus.mem_resp_data  = stray_v ? 32'hDEAD_BEEF : r_data;

    icache_refill #(.LINE_WORDS(LW), .NUM_LINES(NL), .CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct {
        logic [31:0] data;
        bit          hit;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_q[$];
    bit          mvalid[NL];
    logic [31:0] mline[NL];
    int checks = 0, errors = 0, cyc = 0;
    int hit_raw = 0, miss_raw = 0, miss_total = 0, hs_count = 0;
    int flush_beat = -1, reset_beat = -1, force_bp = -1;
    bit reset_event = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a & ~32'h3) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] sat(input int n);
        return (n >= (1 << CW) - 1) ? ((32'd1 << CW) - 32'd1) : 32'(n);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    task automatic send(input logic [31:0] a);
        int n;
        int idx;
        logic [31:0] line;
        exp_t e;
        n = 0;
        while (bus.cpu_req_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (addr %h)", a);
        end
        line = a & ~32'hF;
        idx  = int'(a[7:4]);
        e.hit = mvalid[idx] && (mline[idx] == line);
        if (e.hit) begin
            hit_raw++;
        end else begin
            miss_raw++;
            miss_total++;
            mem_q.push_back(line);
            mvalid[idx] = 1'b1;
            mline[idx]  = line;
        end
        e.data    = mem_word(a);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
        bus.cpu_req_valid = 1'b1;
        bus.cpu_addr      = a;
        @(negedge clk);
        bus.cpu_req_valid = 1'b0;
        bus.cpu_addr      = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || bus.cpu_req_ready !== 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic check_counts(input string nm);
        chk({nm, "_hit_count"}, 32'(hit_count), sat(hit_raw));
        chk({nm, "_miss_count"}, 32'(miss_count), sat(miss_raw));
        chk({nm, "_mem_reqs"}, 32'(hs_count), 32'(miss_total));
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.cpu_resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got %h expected no response", bus.cpu_resp_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_data", bus.cpu_resp_data, e.data);
                    if (e.hit) chk("hit_latency", 32'(cyc), 32'(e.acc_cyc + 2));
                end
            end
        end
    end

    // Memory responder: accepts refill requests and returns the line as beats.
    initial begin
        int dly;
        logic [31:0] a0;
        bit aborted;
        bus.mem_req_ready = 1'b0;
        r_valid = 1'b0; r_data = '0; flush_resp = 1'b0; rst_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_req_valid === 1'b1 && !reset) begin
                a0 = bus.mem_req_addr;
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mem_req: got %h expected none", a0);
                end else begin
                    chk("mem_req_addr", a0, mem_q.pop_front());
                end
                dly = (force_bp >= 0) ? force_bp : int'($urandom_range(0, 2));
                for (int d = 0; d < dly; d++) begin
                    if (force_bp >= 0) begin
                        chk("bp_mem_req_valid", 32'(bus.mem_req_valid), 32'd1);
                        chk("bp_mem_req_addr", bus.mem_req_addr, a0);
                        chk("bp_cpu_req_ready", 32'(bus.cpu_req_ready), 32'd0);
                    end
                    @(negedge clk);
                end
                bus.mem_req_ready = 1'b1;
                @(negedge clk);
                bus.mem_req_ready = 1'b0;
                hs_count++;
                aborted = 1'b0;
                for (int b = 0; b < LW && !aborted; b++) begin
                    if ($urandom_range(0, 1) == 1) @(negedge clk);
                    if (b == reset_beat) begin
                        rst_resp = 1'b1;
                        @(negedge clk);
                        @(negedge clk);
                        rst_resp = 1'b0;
                        reset_event = 1'b1;
                        aborted = 1'b1;
                    end else begin
                        r_valid    = 1'b1;
                        r_data     = mem_word(a0 + 32'(4 * b));
                        flush_resp = (b == flush_beat);
                        @(negedge clk);
                        r_valid    = 1'b0;
                        flush_resp = 1'b0;
                    end
                end
            end
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int n;
        logic [31:0] a;
        rst_drv = 1'b1; flush_drv = 1'b0; stray_v = 1'b0;
        bus.cpu_req_valid = 1'b0; bus.cpu_addr = '0;
        clear_model();
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", 32'(bus.cpu_resp_valid), 32'd0);
        chk("rst_resp_data", bus.cpu_resp_data, 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'd0);
        chk("rst_hit_count", 32'(hit_count), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        rst_drv = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(bus.cpu_req_ready), 32'd1);

        send(32'h100); drain(); check_counts("cold_miss");
        send(32'h10C); drain(); check_counts("hit");
        send(32'h200); send(32'h100); drain(); check_counts("conflict");

        force_bp = 5;
        send(32'h400); drain();
        force_bp = -1;
        check_counts("backpressure");

        flush_beat = 2;
        send(32'h300); drain();
        flush_beat = -1;
        clear_model();
        send(32'h300); send(32'h100); drain(); check_counts("flush_refill");

        reset_beat = 2;
        send(32'h510);
        n = 0;
        while (!reset_event && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL reset_event_timeout: got 0 expected 1");
        end
        reset_beat = -1;
        reset_event = 1'b0;
        sb_q.delete(); mem_q.delete();
        clear_model();
        hit_raw = 0; miss_raw = 0;
        @(negedge clk);
        chk("ready_post_reset", 32'(bus.cpu_req_ready), 32'd1);
        chk("post_reset_hit_count", 32'(hit_count), 32'd0);
        chk("post_reset_miss_count", 32'(miss_count), 32'd0);
        stray_v = 1'b1;
        repeat (3) @(negedge clk);
        stray_v = 1'b0;
        @(negedge clk);
        send(32'h510); send(32'h100); drain(); check_counts("reset_refill");

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                drain();
                flush_drv = 1'b1;
                @(negedge clk);
                flush_drv = 1'b0;
                clear_model();
            end
            a = (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            send(a);
        end
        drain();
        check_counts("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
